// File: rtl/synaptic_current_driver_pkg.sv
// Shared types, fixed-point limits and arithmetic helpers for the synaptic current driver.
// SYN_SATURATE_EN selects clamping arithmetic; without it the helpers wrap in two's complement.
package izh_syn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_APPLY   = 2'd2,
        ST_DECAY   = 2'd3
    } syn_state_e;

    function automatic longint fx_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic longint fx_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    function automatic logic fx_fits(input longint v, input int n);
        return (v <= fx_max(n)) && (v >= fx_min(n));
    endfunction

    // Reinterpret the low n bits of v as a signed n-bit value.
    function automatic longint fx_wrap(input longint v, input int n);
        return (v <<< (64 - n)) >>> (64 - n);
    endfunction

`ifdef SYN_SATURATE_EN
    function automatic longint fx_clamp(input longint v, input int n);
        if (v > fx_max(n)) begin
            return fx_max(n);
        end else if (v < fx_min(n)) begin
            return fx_min(n);
        end else begin
            return v;
        end
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int n);
        return fx_clamp(a + b, n);
    endfunction

    function automatic longint sat_mul_q(input longint a, input longint b, input int n, input int q);
        return fx_clamp((a * b) >>> q, n);
    endfunction
`else
    function automatic longint sat_add(input longint a, input longint b, input int n);
        return fx_wrap(a + b, n);
    endfunction

    function automatic longint sat_mul_q(input longint a, input longint b, input int n, input int q);
        return fx_wrap((a * b) >>> q, n);
    endfunction
`endif

endpackage

// File: rtl/synaptic_current_driver_sat_add.sv
// Combinational N-bit signed adder; ovf_o flags a true sum outside the N-bit range
// regardless of whether the result is clamped or wrapped.
module syn_sat_add
    import izh_syn_pkg::*;
#(
    parameter int N = 18
) (
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    output logic signed [N-1:0] sum_o,
    output logic                ovf_o
);

    longint raw_s;

    // Exact sum for overflow detection, shaped sum for the datapath.
    always_comb begin
        raw_s = longint'(a_i) + longint'(b_i);
        sum_o = N'(sat_add(longint'(a_i), longint'(b_i), N));
        ovf_o = !fx_fits(raw_s, N);
    end

endmodule

// File: rtl/synaptic_current_driver.sv
// Integrates weighted spike events into a decaying synaptic current and strobes i_syn + i_bias
// to the neuron core once per timestep. Optional feature macro: SYN_SATURATE_EN.
module synaptic_current_driver
    import izh_syn_pkg::*;
#(
    parameter int N           = 18,
    parameter int Q           = 10,
    parameter int STEP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                spike_valid,
    input  logic signed [N-1:0] spike_weight,
    output logic                spike_ready,
    input  logic signed [N-1:0] decay,
    input  logic signed [N-1:0] i_bias,
    output logic signed [N-1:0] i_out,
    output logic                apply,
    output logic [15:0]         timestep,
    output logic                sat_flag
);

    localparam int CNT_W = (STEP_CYCLES > 4) ? $clog2(STEP_CYCLES) : 2;
    localparam logic [CNT_W-1:0] COLLECT_LAST = CNT_W'(STEP_CYCLES - 3);

    syn_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic signed [N-1:0] i_syn_q;
    logic signed [N-1:0] i_out_q;
    logic                apply_q;
    logic                ready_q;
    logic [15:0]         timestep_q;

    logic                accept_s;
    logic                last_collect_s;
    logic signed [N-1:0] acc_sum_s;
    logic                acc_ovf_s;
    logic signed [N-1:0] i_syn_d;
    logic signed [N-1:0] out_sum_s;
    logic                out_ovf_s;
    logic signed [N-1:0] prod_s;

    syn_sat_add #(.N(N)) u_acc_add (
        .a_i   (i_syn_q),
        .b_i   (spike_weight),
        .sum_o (acc_sum_s),
        .ovf_o (acc_ovf_s)
    );

    syn_sat_add #(.N(N)) u_bias_add (
        .a_i   (i_syn_d),
        .b_i   (i_bias),
        .sum_o (out_sum_s),
        .ovf_o (out_ovf_s)
    );

    // Next synaptic current including this cycle's event, plus the decay product.
    always_comb begin
        accept_s       = spike_valid & ready_q;
        last_collect_s = (state_q == ST_COLLECT) && (cnt_q == COLLECT_LAST);
        if (accept_s) begin
            i_syn_d = acc_sum_s;
        end else begin
            i_syn_d = i_syn_q;
        end
        prod_s = N'(sat_mul_q(longint'(i_syn_q), longint'(decay), N, Q));
    end

    // Timestep sequencer: COLLECT x (STEP_CYCLES-2), APPLY, DECAY; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            i_syn_q    <= '0;
            i_out_q    <= '0;
            apply_q    <= 1'b0;
            ready_q    <= 1'b0;
            timestep_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    apply_q <= 1'b0;
                    if (enable) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    i_syn_q <= i_syn_d;
                    if (last_collect_s) begin
                        // i_out sees the event accepted on this final collect edge as well.
                        state_q    <= ST_APPLY;
                        ready_q    <= 1'b0;
                        apply_q    <= 1'b1;
                        i_out_q    <= out_sum_s;
                        timestep_q <= timestep_q + 16'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_APPLY: begin
                    apply_q <= 1'b0;
                    state_q <= ST_DECAY;
                end
                ST_DECAY: begin
                    i_syn_q <= prod_s;
                    if (enable) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    apply_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYN_SATURATE_EN
    longint prod_raw_s;
    logic   sat_event_s;
    logic   sat_q;

    // Any clamp that actually lands in state this cycle raises the sticky flag.
    always_comb begin
        prod_raw_s  = (longint'(i_syn_q) * longint'(decay)) >>> Q;
        sat_event_s = (accept_s & acc_ovf_s)
                    | (last_collect_s & out_ovf_s)
                    | ((state_q == ST_DECAY) & !fx_fits(prod_raw_s, N));
    end

    // Sticky saturation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_q | sat_event_s;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = acc_ovf_s ^ out_ovf_s;
    assign sat_flag     = 1'b0;
`endif

    assign spike_ready = ready_q;
    assign i_out       = i_out_q;
    assign apply       = apply_q;
    assign timestep    = timestep_q;

endmodule

// File: tb/tb_synaptic_current_driver.sv
// Scoreboard bench for synaptic_current_driver: directed stimulus pushes expected apply results,
// a monitor pops and compares on every apply pulse.
module tb_synaptic_current_driver;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               spike_valid = 1'b0;
    logic signed [17:0] spike_weight = 18'sd0;
    logic               spike_ready;
    logic signed [17:0] decay = 18'sd512;
    logic signed [17:0] i_bias = 18'sd0;
    logic signed [17:0] i_out;
    logic               apply;
    logic [15:0]        timestep;
    logic               sat_flag;

    typedef struct {
        logic signed [17:0] iout;
        logic [15:0]        ts;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   seen   = 0;

    synaptic_current_driver #(.N(18), .Q(10), .STEP_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .spike_valid  (spike_valid),
        .spike_weight (spike_weight),
        .spike_ready  (spike_ready),
        .decay        (decay),
        .i_bias       (i_bias),
        .i_out        (i_out),
        .apply        (apply),
        .timestep     (timestep),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic expect_apply(input logic signed [17:0] iout, input logic [15:0] ts);
        exp_t e;
        e.iout = iout;
        e.ts   = ts;
        exp_q.push_back(e);
    endtask

    // Monitor: every apply pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        logic prev_apply = 1'b0;
        forever begin
            @(negedge clk);
            if (apply) begin
                if (prev_apply) begin
                    chk("apply_back_to_back", 1, 0);
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_apply_ts", longint'(timestep), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("apply_i_out", longint'(i_out), longint'(e.iout));
                    chk("apply_timestep", longint'(timestep), longint'(e.ts));
                end
                seen++;
            end
            prev_apply = apply;
        end
    end

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        spike_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_spike(input logic signed [17:0] w);
        int n = 0;
        bit done = 1'b0;
        spike_valid  = 1'b1;
        spike_weight = w;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (spike_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
        end
        #1;
        spike_valid = 1'b0;
        chk("spike_accepted", longint'(done), 1);
    endtask

    task automatic wait_seen(input int target, input int budget);
        int n = 0;
        while (seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("apply_arrived", longint'(seen >= target), 1);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!spike_ready && n < budget);
        chk("ready_arrived", longint'(spike_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        logic bad;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_i_out", longint'(i_out), 0);
        chk("rst_apply", longint'(apply), 0);
        chk("rst_spike_ready", longint'(spike_ready), 0);
        chk("rst_timestep", longint'(timestep), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);

        // Single event then pure decay by 0.5 per step
        expect_apply(18'sd1024, 16'd1);
        expect_apply(18'sd512, 16'd2);
        expect_apply(18'sd256, 16'd3);
        expect_apply(18'sd128, 16'd4);
        enable = 1'b1;
        send_spike(18'sd1024);
        wait_seen(4, 40);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("decay_sat_flag", longint'(sat_flag), 0);

        // Two max-weight events in one step
        do_reset();
        base = seen;
`ifdef SYN_SATURATE_EN
        expect_apply(18'sd131071, 16'd1);
`else
        expect_apply(-18'sd2, 16'd1);
`endif
        enable = 1'b1;
        send_spike(18'sd131071);
        send_spike(18'sd131071);
        wait_seen(base + 1, 20);
        enable = 1'b0;
        @(negedge clk);
`ifdef SYN_SATURATE_EN
        chk("overflow_sat_flag", longint'(sat_flag), 1);
`else
        chk("overflow_sat_flag", longint'(sat_flag), 0);
`endif
        repeat (4) @(negedge clk);

        // Negative event with bias
        do_reset();
        base   = seen;
        i_bias = 18'sd2048;
        expect_apply(18'sd1024, 16'd1);
        expect_apply(18'sd1536, 16'd2);
        enable = 1'b1;
        send_spike(-18'sd1024);
        wait_seen(base + 2, 20);
        enable = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during COLLECT with a pending event
        i_bias = 18'sd0;
        enable = 1'b1;
        wait_ready(10);
        spike_valid  = 1'b1;
        spike_weight = 18'sd5000;
        rst          = 1'b1;
        enable       = 1'b0;
        @(negedge clk);
        chk("midrst_apply", longint'(apply), 0);
        chk("midrst_spike_ready", longint'(spike_ready), 0);
        chk("midrst_i_out", longint'(i_out), 0);
        chk("midrst_timestep", longint'(timestep), 0);
        rst         = 1'b0;
        spike_valid = 1'b0;
        @(negedge clk);

        // First-pulse latency and step spacing; i_syn must have been cleared
        base = seen;
        expect_apply(18'sd0, 16'd1);
        expect_apply(18'sd0, 16'd2);
        enable = 1'b1;
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            bad = bad | apply;
        end
        @(negedge clk);
        chk("first_apply_latency", longint'(apply), 1);
        repeat (3) begin
            @(negedge clk);
            bad = bad | apply;
        end
        @(negedge clk);
        chk("apply_period", longint'(apply), 1);
        chk("no_early_apply", longint'(bad), 0);
        enable = 1'b0;
        repeat (6) @(negedge clk);

        // Timestep wrap, then enable dropped mid-COLLECT
        @(negedge clk);
        force dut.timestep_q = 16'hFFFE;
        @(negedge clk);
        release dut.timestep_q;
        @(negedge clk);
        chk("preload_timestep", longint'(timestep), 65534);
        base = seen;
        expect_apply(18'sd0, 16'hFFFF);
        expect_apply(18'sd0, 16'h0000);
        expect_apply(18'sd0, 16'h0001);
        enable = 1'b1;
        wait_seen(base + 2, 20);
        wait_ready(10);
        enable = 1'b0;
        wait_seen(base + 3, 10);
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            bad = bad | spike_ready | apply;
        end
        chk("idle_after_drop", longint'(bad), 0);
        chk("final_timestep", longint'(timestep), 1);
        chk("queue_drained", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
